// File: rtl/dma_axil_regs.sv
// dma_axil_regs: AXI4-Lite slave register file for the DMA engine.
//
// Register map (byte offsets, word aligned):
//   0x00 CTRL   bit0 START (write-1 pulses dma_start, reads 0), bit1 IRQ_EN (RW)
//   0x04 STATUS bit0 BUSY (live dma_busy), bit1 DONE (sticky, W1C)
//   0x08 ADDR   RW, drives dma_addr
//   0x0C LEN    RW, drives dma_len
//   0x10 ID     RO, ID_VAL
//   anything else -> SLVERR, write dropped, read data 0
//
// Ports:
//   clk, rst          clock, async active-high reset
//   aw*/w*/b*         AXI-Lite write channels (awprot ignored)
//   ar*/r*            AXI-Lite read channels (arprot ignored)
//   dma_start_o-style core interface: dma_start (1-cycle pulse), dma_addr,
//   dma_len, dma_busy (level in), dma_done (1-cycle pulse in)
//   irq               level interrupt = IRQ_EN & DONE
module dma_axil_regs #(
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 32,
  parameter logic [31:0] ID_VAL = 32'h4A32_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic              dma_start,
  output logic [DATA_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_len,
  input  logic              dma_busy,
  input  logic              dma_done,
  output logic              irq
);

  localparam logic [2:0] R_CTRL   = 3'd0;
  localparam logic [2:0] R_STATUS = 3'd1;
  localparam logic [2:0] R_ADDR   = 3'd2;
  localparam logic [2:0] R_LEN    = 3'd3;
  localparam logic [2:0] R_ID     = 3'd4;
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;

  logic                aw_held_q, aw_held_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic                w_held_q, w_held_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   len_q, len_d;

  logic                aw_hs, w_hs, ar_hs, commit;
  logic                wr_hit, rd_hit;
  logic [DATA_W-1:0]   rd_word;

  // Protection bits and byte-offset bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, awaddr_q[1:0], araddr[1:0]};

  assign awready = !aw_held_q && !bvalid_q;
  assign wready  = !w_held_q  && !bvalid_q;
  assign arready = !rvalid_q;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid  && wready;
  assign ar_hs   = arvalid && arready;
  // Both halves parked and the B slot free: the write retires this edge.
  assign commit  = aw_held_q && w_held_q && !bvalid_q;

  assign wr_hit = (awaddr_q[ADDR_W-1:5] == '0) && (awaddr_q[4:2] <= R_ID);
  assign rd_hit = (araddr[ADDR_W-1:5]   == '0) && (araddr[4:2]   <= R_ID);

  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign dma_start = start_q;
  assign dma_addr  = addr_q;
  assign dma_len   = len_q;
  assign irq       = irq_en_q && done_q;

  // Read mux over pre-commit register state.
  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      case (araddr[4:2])
        R_CTRL:   rd_word[1] = irq_en_q;
        R_STATUS: begin
          rd_word[0] = dma_busy;
          rd_word[1] = done_q;
        end
        R_ADDR:   rd_word = addr_q;
        R_LEN:    rd_word = len_q;
        R_ID:     rd_word = ID_VAL;
        default:  rd_word = '0;
      endcase
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    irq_en_d  = irq_en_q;
    addr_d    = addr_q;
    len_d     = len_q;
    start_d   = 1'b0;
    done_d    = done_q || dma_done;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
    if (bvalid_q && bready) bvalid_d = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_hit ? OKAY : SLVERR;
      if (wr_hit) begin
        case (awaddr_q[4:2])
          R_CTRL: if (wstrb_q[0]) begin
            irq_en_d = wdata_q[1];
            start_d  = wdata_q[0] && !dma_busy;
          end
          // A done pulse on the clearing edge keeps DONE set.
          R_STATUS: if (wstrb_q[0] && wdata_q[1]) done_d = dma_done;
          R_ADDR: for (int b = 0; b < DATA_W/8; b++)
            if (wstrb_q[b]) addr_d[8*b +: 8] = wdata_q[8*b +: 8];
          R_LEN: for (int b = 0; b < DATA_W/8; b++)
            if (wstrb_q[b]) len_d[8*b +: 8] = wdata_q[8*b +: 8];
          default: ;
        endcase
      end
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_hit ? OKAY : SLVERR;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      start_q   <= start_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
    end
  end

endmodule

// File: doc/dma_axil_regs.md
# dma_axil_regs

AXI4-Lite slave register file for the DMA engine: the control/status endpoint that the AXI-Lite master (testbench BFM or CPU) writes and reads. It decodes word-aligned accesses into a small register map and drives the DMA core with a start pulse, transfer address and length. It also collects the core's busy/done status and raises a level interrupt.

## Interface
- ADDR_W, 8, AXI-Lite address width; only addr[4:2] are decoded, and addr[ADDR_W-1:5] must be zero for a hit.
- DATA_W, 32, data width; fixed at 32, other values unsupported.
- ID_VAL, 32'h4A32_0001, constant returned by the ID register.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- awaddr in ADDR_W, awprot in 3 (ignored), awvalid in 1, awready out 1
- wdata in 32, wstrb in 4, wvalid in 1, wready out 1
- bresp out 2, bvalid out 1, bready in 1
- araddr in ADDR_W, arprot in 3 (ignored), arvalid in 1, arready out 1
- rdata out 32, rresp out 2, rvalid out 1, rready in 1
- dma_start  out  1  one-cycle start pulse to the DMA core.
- dma_addr  out  32  transfer base address (ADDR register).
- dma_len  out  32  transfer length in bytes (LEN register).
- dma_busy  in  1  core busy level.
- dma_done  in  1  one-cycle completion pulse from the core.
- irq  out  1  level interrupt = IRQ_EN & DONE.

## Operation
Register map (byte offsets):
- 0x00 CTRL: bit0 START, write-1 issues dma_start and always reads 0; bit1 IRQ_EN, RW. Other bits read 0.
- 0x04 STATUS: bit0 BUSY, RO mirror of dma_busy; bit1 DONE, sticky, set by dma_done, cleared by writing 1 (W1C).
- 0x08 ADDR: RW, 32 bit.
- 0x0C LEN: RW, 32 bit.
- 0x10 ID: RO, reads ID_VAL.
- Any other offset returns SLVERR (2'b10): the write is discarded and the read returns 0. Mapped accesses return OKAY (2'b00). Writes to RO registers return OKAY and are ignored.

Write path:
- AW and W are captured independently into aw_held / w_held; either may arrive first or both together.
- awready = !aw_held & !bvalid; wready = !w_held & !bvalid.
- Commit when aw_held & w_held & !bvalid. The commit sets bvalid and bresp and clears both held flags.
- wstrb byte enables apply to ADDR and LEN. CTRL and STATUS act only if wstrb[0]=1.
- START is ignored while dma_busy=1: no pulse is issued, and the response is still OKAY.

Read path:
- arready = !rvalid. On AR handshake, rdata, rresp and rvalid are registered at the same edge.
- rdata reflects register state before any write committing on that same edge.
- rvalid, rdata and rresp hold stable until rready.

Read and write paths are fully independent and may complete on the same cycle.

## Timing
- Reset (async assert): awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, dma_start=0, dma_addr=0, dma_len=0, irq=0. CTRL.IRQ_EN=0, DONE=0, held flags cleared.
- Write latency: AW+W handshake at edge N; commit and bvalid=1 at edge N+1. Register value is visible at N+1, and dma_start is high for the cycle following N+1. If AW and W are split, commit occurs one edge after the later handshake.
- B stall: while bvalid & !bready, awready=wready=0 and nothing further is accepted. Release is on the bvalid&bready edge, with readies high the next cycle.
- Read latency: rvalid=1 the cycle after the AR handshake. Back-to-back reads run at one per 2 cycles when rready is held at 1.
- DONE set and W1C on the same cycle: set wins, so DONE stays 1.
- irq is combinational from registered IRQ_EN and DONE, with no extra latency beyond those registers.
- Reset asserted mid-transaction abandons held AW/W and any pending B/R. No response is produced for them.

## Test plan
- Reset, then read 0x10 -> rdata=0x4A320001, rresp=0; read 0x04 with dma_busy=0 -> 0x0.
- Write 0x08=0x1000_0040 and 0x0C=0x0000_0100, read back -> same values; dma_addr and dma_len match. Write 0x08 data 0xFFFF_FFFF with wstrb=4'b0011 -> reads 0x1000_FFFF.
- AW presented 3 cycles before W; then W before AW; with bready=0 for 4 cycles -> single commit each time, bvalid held, awready=wready=0 until bready.
- Write CTRL=0x3 with dma_busy=0 -> one-cycle dma_start, CTRL reads 0x2. Drive dma_done -> STATUS=0x2, irq=1. Write STATUS=0x2 -> DONE=0, irq=0. Repeat with dma_done coincident with the W1C -> DONE stays 1.
- Write CTRL=0x1 while dma_busy=1 -> no dma_start, bresp=0.
- Write and read 0x14 and 0x40 -> bresp=rresp=2'b10, rdata=0, no register changed.
- Concurrent read of 0x08 on the write-commit edge -> old value; subsequent read returns new value.
